// File: rtl/fx2lp_stream_in_writer.sv
// FX2LP slave-FIFO stream-IN master.
// Pushes one word per clock into the FX2 endpoint FIFO while flagd reports
// space, sourcing words from the ADC, a 256-entry sine table or a counter,
// and frames the stream into PKT_LEN-word packets closed by a pkt_end strobe.
module fx2lp_stream_in_writer #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADC_W      = 12,
  parameter int unsigned PKT_LEN    = 512,
  parameter int unsigned DONE_DELAY = 10,
  parameter logic [1:0]  FIFO_ADDR  = 2'b10
) (
  input  logic              clk_out_0,
  input  logic              reset_n,
  input  logic              flagd,
  input  logic              sync,
  input  logic [1:0]        mode,
  input  logic [7:0]        phase_step,
  input  logic [ADC_W-1:0]  data_adc,
  output logic [DATA_W-1:0] fdata,
  output logic [1:0]        faddr,
  output logic              slwr,
  output logic              slrd,
  output logic              sloe,
  output logic              pkt_end,
  output logic              done,
  output logic [15:0]       pkt_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WRITE  = 2'd1;
  localparam logic [1:0] PKTEND = 2'd2;

  localparam int unsigned WI_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int unsigned DC_W = $clog2(DONE_DELAY + 1) + 1;

  localparam logic [DC_W-1:0] DONE_CNT = DC_W'(DONE_DELAY);
  localparam logic [WI_W-1:0] LAST_IDX = WI_W'((PKT_LEN == 0) ? 0 : PKT_LEN - 1);

  // First quadrant (k = 0..64) of floor(127.5 + 127*sin(2*pi*k/256)).
  // The rest of the period follows from LUT[128-k] = LUT[k] and
  // LUT[k+128] = 254 - LUT[k] (127*sin never lands on a half integer).
  localparam logic [7:0] QSINE [0:64] = '{
    8'd127, 8'd130, 8'd133, 8'd136, 8'd139, 8'd143, 8'd146, 8'd149, 8'd152, 8'd155,
    8'd158, 8'd161, 8'd164, 8'd167, 8'd170, 8'd173, 8'd176, 8'd178, 8'd181, 8'd184,
    8'd187, 8'd190, 8'd192, 8'd195, 8'd198, 8'd200, 8'd203, 8'd205, 8'd208, 8'd210,
    8'd212, 8'd215, 8'd217, 8'd219, 8'd221, 8'd223, 8'd225, 8'd227, 8'd229, 8'd231,
    8'd233, 8'd234, 8'd236, 8'd238, 8'd239, 8'd240, 8'd242, 8'd243, 8'd244, 8'd245,
    8'd247, 8'd248, 8'd249, 8'd249, 8'd250, 8'd251, 8'd252, 8'd252, 8'd253, 8'd253,
    8'd253, 8'd254, 8'd254, 8'd254, 8'd254
  };

  function automatic logic [7:0] sine_lut(input logic [7:0] idx);
    logic [6:0] k;
    logic [7:0] v;
    k = idx[6] ? (7'd64 - {1'b0, idx[5:0]}) : {1'b0, idx[5:0]};
    v = QSINE[k];
    return idx[7] ? (8'd254 - v) : v;
  endfunction

  logic [1:0]        state;
  logic [1:0]        mode_l;
  logic [DC_W-1:0]   dcnt;
  logic [WI_W-1:0]   widx;
  logic [7:0]        lut_idx;
  logic [DATA_W-1:0] ctr;

  logic              wr_en;
  logic              last_word;
  logic [1:0]        mode_sel;
  logic [7:0]        lut_idx_nxt;
  logic [DATA_W-1:0] ctr_nxt;
  logic [15:0]       adc_ext;
  logic [7:0]        adc_top;
  logic [DATA_W-1:0] adc_word;
  logic [DATA_W-1:0] sample;

  assign faddr   = FIFO_ADDR;
  assign slrd    = 1'b1;
  assign sloe    = 1'b1;
  assign wr_en   = (state == WRITE) && flagd;
  assign slwr    = ~wr_en;
  assign pkt_end = (state != PKTEND);

  assign last_word   = (PKT_LEN != 0) && (widx == LAST_IDX);
  assign lut_idx_nxt = wr_en ? (lut_idx + phase_step) : lut_idx;
  assign ctr_nxt     = wr_en ? (ctr + DATA_W'(1)) : ctr;

  // In IDLE the live mode is used so the word preloaded on the entry edge
  // matches the mode latched on that same edge.
  assign mode_sel = (state == IDLE) ? mode : mode_l;

  assign adc_ext  = 16'(data_adc);
  assign adc_top  = data_adc[ADC_W-1 -: 8];
  assign adc_word = (DATA_W == 8) ? DATA_W'(adc_top) : DATA_W'(adc_ext);

  // Next word for the FIFO bus from the selected source.
  always_comb begin
    sample = '0;
    case (mode_sel)
      2'd0:    sample = adc_word;
      2'd1:    sample = DATA_W'(sine_lut(lut_idx_nxt));
      default: sample = ctr_nxt;
    endcase
  end

  // Startup delay: saturating count, done held high once reached.
  always_ff @(posedge clk_out_0 or negedge reset_n) begin
    if (!reset_n) begin
      dcnt <= '0;
      done <= 1'b0;
    end else if (dcnt != DONE_CNT) begin
      dcnt <= dcnt + DC_W'(1);
      done <= ((dcnt + DC_W'(1)) == DONE_CNT);
    end else begin
      done <= 1'b1;
    end
  end

  // Write/packet-end sequencing, mode latch and completed-packet count.
  always_ff @(posedge clk_out_0 or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      mode_l  <= '0;
      pkt_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (done && flagd && sync) begin
            state  <= WRITE;
            mode_l <= mode;
          end
        end
        WRITE: begin
          if (!flagd) begin
            state <= IDLE;
          end else if (last_word) begin
            state <= PKTEND;
          end
        end
        PKTEND: begin
          pkt_cnt <= pkt_cnt + 16'd1;
          state   <= flagd ? WRITE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-write advance of packet position, sine phase and counter source.
  always_ff @(posedge clk_out_0 or negedge reset_n) begin
    if (!reset_n) begin
      widx    <= '0;
      lut_idx <= '0;
      ctr     <= '0;
    end else if (wr_en) begin
      lut_idx <= lut_idx_nxt;
      ctr     <= ctr_nxt;
      if (PKT_LEN != 0) begin
        widx <= last_word ? '0 : (widx + WI_W'(1));
      end
    end
  end

  // FIFO data register: loads on writes and while idle, held otherwise.
  always_ff @(posedge clk_out_0 or negedge reset_n) begin
    if (!reset_n) begin
      fdata <= '0;
    end else if (wr_en || (state == IDLE)) begin
      fdata <= sample;
    end
  end

endmodule

// File: tb/tb_fx2lp_stream_in_writer.sv
// Scoreboard bench for fx2lp_stream_in_writer: stimulus queues the expected
// write words and packet-end strobes; a monitor pops them as the DUT presents
// slwr/pkt_end. A second DUT (8-bit, free streaming) covers the narrow path.
`timescale 1ns/1ps
module tb_fx2lp_stream_in_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flagd = 1'b0;
  logic        sync = 1'b0;
  logic [1:0]  mode = 2'd2;
  logic [7:0]  phase_step = 8'd0;
  logic [11:0] data_adc = 12'h000;

  logic [15:0] fdata;
  logic [1:0]  faddr;
  logic        slwr, slrd, sloe, pkt_end, done;
  logic [15:0] pkt_cnt;

  logic [7:0]  fdata8;
  logic [1:0]  faddr8;
  logic        slwr8, slrd8, sloe8, pkt_end8, done8;
  logic [15:0] pkt_cnt8;

  always #5 clk = ~clk;

  fx2lp_stream_in_writer #(
    .DATA_W(16), .ADC_W(12), .PKT_LEN(4), .DONE_DELAY(10), .FIFO_ADDR(2'b10)
  ) dut (
    .clk_out_0(clk), .reset_n(reset_n), .flagd(flagd), .sync(sync),
    .mode(mode), .phase_step(phase_step), .data_adc(data_adc),
    .fdata(fdata), .faddr(faddr), .slwr(slwr), .slrd(slrd), .sloe(sloe),
    .pkt_end(pkt_end), .done(done), .pkt_cnt(pkt_cnt)
  );

  fx2lp_stream_in_writer #(
    .DATA_W(8), .ADC_W(12), .PKT_LEN(0), .DONE_DELAY(10), .FIFO_ADDR(2'b10)
  ) dut8 (
    .clk_out_0(clk), .reset_n(reset_n), .flagd(flagd), .sync(sync),
    .mode(mode), .phase_step(phase_step), .data_adc(data_adc),
    .fdata(fdata8), .faddr(faddr8), .slwr(slwr8), .slrd(slrd8), .sloe(sloe8),
    .pkt_end(pkt_end8), .done(done8), .pkt_cnt(pkt_cnt8)
  );

  typedef struct packed {
    logic        is_pkt;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   wr_main = 0;
  int   wr8 = 0;
  int   pe8 = 0;
  bit   mon_en = 1'b0;

  // Main DUT monitor: every write word and packet-end strobe must match the queue head.
  always @(negedge clk) begin
    if (reset_n && mon_en) begin
      if (!slwr) begin
        wr_main++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_word: got write %h, required no write", fdata);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.is_pkt || (fdata !== mon_e.val)) begin
            errors++;
            $display("FAIL sb_word: got write %h, required %s %h", fdata,
                     mon_e.is_pkt ? "pkt_end" : "word", mon_e.val);
          end
        end
      end
      if (!pkt_end) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_pkt_end: got pkt_end, required nothing");
        end else begin
          mon_e = exp_q.pop_front();
          if (!mon_e.is_pkt) begin
            errors++;
            $display("FAIL sb_pkt_end: got pkt_end, required word %h", mon_e.val);
          end
        end
      end
    end
  end

  // Narrow DUT activity counters.
  always @(negedge clk) begin
    if (reset_n) begin
      if (!slwr8) wr8++;
      if (!pkt_end8) pe8++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push_w(input logic [15:0] v);
    exp_q.push_back('{is_pkt: 1'b0, val: v});
  endtask

  task automatic push_p();
    exp_q.push_back('{is_pkt: 1'b1, val: 16'h0000});
  endtask

  // Four words, the packet-end strobe, then the first word of the next packet.
  task automatic push_pkt(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d,
                          input logic [15:0] e);
    push_w(a); push_w(b); push_w(c); push_w(d); push_p(); push_w(e);
  endtask

  task automatic start_run(input logic [1:0] m, input logic [7:0] ps);
    reset_n = 1'b0;
    mon_en = 1'b0;
    mode = m;
    phase_step = ps;
    flagd = 1'b1;
    sync = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic stop_flow();
    #2;
    flagd = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_writes(input string name, input int target);
    int n;
    n = 0;
    while (wr_main < target && n < 300) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (wr_main < target) begin
      errors++;
      $display("FAIL %s_wait: got %0d writes, required %0d", name, wr_main, target);
    end
  endtask

  initial begin
    int first;
    int base;
    int n;

    // Reset state
    #1;
    check("rst_fdata", 32'(fdata), 32'h0);
    check("rst_slwr", 32'(slwr), 32'h1);
    check("rst_pkt_end", 32'(pkt_end), 32'h1);
    check("rst_done", 32'(done), 32'h0);
    check("rst_pkt_cnt", 32'(pkt_cnt), 32'h0);
    check("faddr", 32'(faddr), 32'h2);
    check("slrd_sloe", {30'h0, slrd, sloe}, 32'h3);

    // 1: counter source, done delay, packet framing
    push_pkt(16'd0, 16'd1, 16'd2, 16'd3, 16'd4);
    push_w(16'd5);
    start_run(2'd2, 8'd0);
    first = 0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk);
      #1;
      if (done && first == 0) first = i;
    end
    check("done_delay", 32'(first), 32'd10);
    wait_drain("counter");
    stop_flow();
    check("pkt_cnt_one", 32'(pkt_cnt), 32'd1);

    // 2: sine source at three phase steps
    push_pkt(16'h7F, 16'h82, 16'h85, 16'h88, 16'h8B);
    start_run(2'd1, 8'd1);
    wait_drain("sine_step1");
    stop_flow();
    push_pkt(16'h7F, 16'hFE, 16'h7F, 16'h00, 16'h7F);
    start_run(2'd1, 8'd64);
    wait_drain("sine_step64");
    stop_flow();
    push_pkt(16'h7F, 16'h8B, 16'h98, 16'hA4, 16'hB0);
    start_run(2'd1, 8'd4);
    wait_drain("sine_step4");
    stop_flow();

    // 3: ADC source, 16-bit zero-extended and 8-bit top byte
    data_adc = 12'hABC;
    push_pkt(16'h0ABC, 16'h0ABC, 16'h0ABC, 16'h0ABC, 16'h0ABC);
    start_run(2'd0, 8'd0);
    n = 0;
    while (slwr8 !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("adc8_fdata", 32'(fdata8), 32'hAB);
    wait_drain("adc16");
    stop_flow();

    // 4: flagd low for 3 cycles before word 2
    push_pkt(16'd0, 16'd1, 16'd2, 16'd3, 16'd4);
    base = wr_main;
    start_run(2'd2, 8'd0);
    wait_writes("stall_mid", base + 2);
    #2;
    flagd = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_mid_slwr", 32'(slwr), 32'h1);
      check("stall_mid_fdata", 32'(fdata), 32'd2);
    end
    @(posedge clk);
    #2;
    flagd = 1'b1;
    wait_drain("stall_mid");
    stop_flow();

    // 5: flagd falls on the cycle of the last word of the packet
    push_pkt(16'd0, 16'd1, 16'd2, 16'd3, 16'd4);
    base = wr_main;
    start_run(2'd2, 8'd0);
    wait_writes("stall_last", base + 3);
    #2;
    flagd = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_last_pkt_end", 32'(pkt_end), 32'h1);
      check("stall_last_fdata", 32'(fdata), 32'd3);
    end
    @(posedge clk);
    #2;
    flagd = 1'b1;
    wait_drain("stall_last");
    stop_flow();
    check("stall_last_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // 6a: asynchronous reset mid-packet
    push_pkt(16'd0, 16'd1, 16'd2, 16'd3, 16'd4);
    start_run(2'd2, 8'd0);
    wait_drain("async_rst");
    #1;
    check("pre_rst_pkt_cnt", 32'(pkt_cnt), 32'd1);
    check("pre_rst_slwr", 32'(slwr), 32'h0);
    #1;
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async_slwr", 32'(slwr), 32'h1);
    check("async_pkt_end", 32'(pkt_end), 32'h1);
    check("async_fdata", 32'(fdata), 32'h0);
    check("async_pkt_cnt", 32'(pkt_cnt), 32'h0);
    check("async_done", 32'(done), 32'h0);

    // 6b: free streaming on the 8-bit instance, 1000 words
    mode = 2'd2;
    flagd = 1'b1;
    sync = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    base = wr8;
    first = pe8;
    n = 0;
    while ((wr8 - base) < 1000 && n < 1300) begin
      @(posedge clk);
      n++;
    end
    check("free_writes", 32'(wr8 - base), 32'd1000);
    #2;
    flagd = 1'b0;
    #1;
    check("free_pkt_end", 32'(pe8 - first), 32'd0);
    check("free_fdata8", 32'(fdata8), 32'd232);
    check("free_pkt_cnt", 32'(pkt_cnt8), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
